pipeline_ctrl: RTL

Hazard and sequencing controller for the 5-stage 8-bit datapath. It generates the per-cycle enable and flush controls for the PC and the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves three conditions:
- load-use hazards on the top/bottom register-file operands,
- multi-cycle memory wait states from the memory I/O buffer,
- taken branches and return-address sequencing.

It sits beside the datapath, with one control wire bundle to each stage register.

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/pipeline_ctrl_hazard_detect.sv | 31 +++
 rtl/pipeline_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StRetWait = 2'd2,
        StError   = 2'd3
    } ctrl_state_e;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_RET    = 2'd2;

    localparam int unsigned DEFAULT_REG_ADDR_W = 5;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: an EX-stage load whose enabled destination feeds a used ID operand.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_src_top_addr_i,
    input  logic [REG_ADDR_W-1:0] id_src_bot_addr_i,
    input  logic                  id_src_top_used_i,
    input  logic                  id_src_bot_used_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_top_addr_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_bot_addr_i,
    input  logic [1:0]            ex_wen_i,
    input  logic                  ex_is_load_i,
    output logic                  stall_o
);

    logic top_hit;
    logic bot_hit;

    // Either source may collide with either destination.
    assign top_hit = id_src_top_used_i &
                     ((ex_wen_i[0] & (id_src_top_addr_i == ex_dst_top_addr_i)) |
                      (ex_wen_i[1] & (id_src_top_addr_i == ex_dst_bot_addr_i)));
    assign bot_hit = id_src_bot_used_i &
                     ((ex_wen_i[0] & (id_src_bot_addr_i == ex_dst_top_addr_i)) |
                      (ex_wen_i[1] & (id_src_bot_addr_i == ex_dst_bot_addr_i)));

    assign stall_o = ex_is_load_i & (top_hit | bot_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline (Mealy outputs).
// Define MEM_TIMEOUT_EN to enable the memory-wait timeout and the sticky ERROR state.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = DEFAULT_REG_ADDR_W,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned RET_DRAIN   = 3
) (
    input  logic                  clock_i,
    input  logic                  nreset_i,
    input  logic [REG_ADDR_W-1:0] id_src_top_addr_i,
    input  logic [REG_ADDR_W-1:0] id_src_bot_addr_i,
    input  logic                  id_src_top_used_i,
    input  logic                  id_src_bot_used_i,
    input  logic                  id_is_ret_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_top_addr_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_bot_addr_i,
    input  logic [1:0]            ex_wen_i,
    input  logic                  ex_is_load_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    input  logic                  branch_taken_i,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  id_ex_en_o,
    output logic                  ex_mem_en_o,
    output logic                  mem_wb_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  mem_wb_flush_o,
    output logic [1:0]            pc_sel_o,
    output logic                  mem_busy_o,
    output logic                  timeout_err_o
);

    localparam int unsigned WaitW   = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned RetCntW = (RET_DRAIN > 1) ? $clog2(RET_DRAIN) : 1;

    ctrl_state_e        state_q, state_d;
    ctrl_state_e        ret_state_q, ret_state_d;
    logic [RetCntW-1:0] ret_cnt_q, ret_cnt_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;

    logic load_use;
    logic mem_stall;
    logic act_freeze, act_branch, act_lu, act_ret_hold, act_ret_fire, act_error;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard_detect (
        .id_src_top_addr_i(id_src_top_addr_i),
        .id_src_bot_addr_i(id_src_bot_addr_i),
        .id_src_top_used_i(id_src_top_used_i),
        .id_src_bot_used_i(id_src_bot_used_i),
        .ex_dst_top_addr_i(ex_dst_top_addr_i),
        .ex_dst_bot_addr_i(ex_dst_bot_addr_i),
        .ex_wen_i         (ex_wen_i),
        .ex_is_load_i     (ex_is_load_i),
        .stall_o          (load_use)
    );

    assign mem_stall = mem_req_i & ~mem_ack_i;

    // Next state plus a one-hot "action" for the output decoder.
    always_comb begin
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        ret_cnt_d    = ret_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        act_freeze   = 1'b0;
        act_branch   = 1'b0;
        act_lu       = 1'b0;
        act_ret_hold = 1'b0;
        act_ret_fire = 1'b0;
        act_error    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    act_freeze  = 1'b1;
                    state_d     = StMemWait;
                    ret_state_d = StRun;
                    wait_cnt_d  = WaitW'(1);
                end else if (branch_taken_i) begin
                    act_branch = 1'b1;
                end else if (load_use) begin
                    act_lu = 1'b1;
                end else if (id_is_ret_i) begin
                    act_ret_hold = 1'b1;
                    state_d      = StRetWait;
                    ret_cnt_d    = RetCntW'(RET_DRAIN - 1);
                end
            end
            StMemWait: begin
                if (!mem_ack_i) begin
                    act_freeze = 1'b1;
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                    end
`ifdef MEM_TIMEOUT_EN
                    if (wait_cnt_q >= WaitW'(MEM_TIMEOUT)) begin
                        state_d = StError;
                    end
`endif
                end else begin
                    // Ack cycle: normal flow resumes on the held inputs.
                    state_d = ret_state_q;
                    if (branch_taken_i) begin
                        act_branch = 1'b1;
                    end else if (load_use) begin
                        act_lu = 1'b1;
                    end
                end
            end
            StRetWait: begin
                if (mem_stall) begin
                    act_freeze  = 1'b1;
                    state_d     = StMemWait;
                    ret_state_d = StRetWait;
                    wait_cnt_d  = WaitW'(1);
                end else if (ret_cnt_q == '0) begin
                    act_ret_fire = 1'b1;
                    state_d      = StRun;
                end else begin
                    act_ret_hold = 1'b1;
                    ret_cnt_d    = ret_cnt_q - RetCntW'(1);
                end
            end
            StError: begin
`ifdef MEM_TIMEOUT_EN
                act_error = 1'b1;
`else
                state_d = StRun;
`endif
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        ex_mem_en_o    = 1'b1;
        mem_wb_en_o    = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        mem_wb_flush_o = 1'b0;
        pc_sel_o       = PC_SEQ;
        mem_busy_o     = 1'b0;
        if (!nreset_i || act_error) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_en_o    = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (act_freeze) begin
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
            mem_busy_o     = 1'b1;
        end else if (act_branch) begin
            pc_sel_o      = PC_BRANCH;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (act_lu) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (act_ret_hold) begin
            pc_en_o       = 1'b0;
            if_id_flush_o = 1'b1;
        end else if (act_ret_fire) begin
            pc_sel_o      = PC_RET;
            if_id_flush_o = 1'b1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic timeout_q;
    assign timeout_err_o = timeout_q & nreset_i;
`else
    assign timeout_err_o = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (!nreset_i) begin
            state_q     <= StRun;
            ret_state_q <= StRun;
            ret_cnt_q   <= '0;
            wait_cnt_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            ret_cnt_q   <= ret_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
`ifdef MEM_TIMEOUT_EN
            timeout_q   <= timeout_q | (state_d == StError);
`endif
        end
    end

endmodule
